// File: rtl/avalon_button_led_pio_if.sv
// Avalon-MM register-bus bundle between the HPS lightweight bridge (master)
// and the button/LED PIO responder (slave).
interface avalon_button_led_pio_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/avalon_button_led_pio.sv
// Avalon-MM responder: debounced push-buttons with sticky press capture and
// maskable level interrupt, plus a software-driven LED register.
module avalon_button_led_pio #(
    parameter int unsigned BTN_WIDTH       = 4,
    parameter int unsigned LED_WIDTH       = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    avalon_button_led_pio_if.slave avs,
    output logic                   irq,
    input  logic [BTN_WIDTH-1:0]   btn_n_in,
    output logic [LED_WIDTH-1:0]   led_out
);

    localparam int unsigned     CntW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrLed  = 2'd1;
    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; presets to released so reset never fakes a press
    // ------------------------------------------------------------------
    logic [BTN_WIDTH-1:0] sync1_q;
    logic [BTN_WIDTH-1:0] sync2_q;
    logic [BTN_WIDTH-1:0] btn_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n_in;
            sync2_q <= sync1_q;
        end
    end

    assign btn_sync = ~sync2_q;

    // ------------------------------------------------------------------
    // Per-bit debouncer: accept a change only after it is seen for
    // DEBOUNCE_CYCLES consecutive cycles
    // ------------------------------------------------------------------
    logic [CntW-1:0]      cnt_q [BTN_WIDTH];
    logic [CntW-1:0]      cnt_d [BTN_WIDTH];
    logic [BTN_WIDTH-1:0] db_q;
    logic [BTN_WIDTH-1:0] db_d;
    logic [BTN_WIDTH-1:0] db_prev_q;
    logic [BTN_WIDTH-1:0] press;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (btn_sync[i] != db_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            db_q      <= '0;
            db_prev_q <= '0;
        end else begin
            for (int i = 0; i < BTN_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    assign press = db_q & ~db_prev_q;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic                 wr_led;
    logic                 wr_mask;
    logic                 wr_edge;
    logic [LED_WIDTH-1:0] led_q;
    logic [LED_WIDTH-1:0] led_d;
    logic [BTN_WIDTH-1:0] mask_q;
    logic [BTN_WIDTH-1:0] mask_d;
    logic [BTN_WIDTH-1:0] edge_q;
    logic [BTN_WIDTH-1:0] edge_d;
    logic [BTN_WIDTH-1:0] edge_clr;
    logic                 irq_q;
    logic                 irq_d;
    logic [31:0]          rdata_mux;
    logic [31:0]          readdata_q;
    logic [31:0]          readdata_d;
    logic                 unused_wdata;

    assign wr_led  = avs.avs_write && (avs.avs_address == AddrLed);
    assign wr_mask = avs.avs_write && (avs.avs_address == AddrMask);
    assign wr_edge = avs.avs_write && (avs.avs_address == AddrEdge);

    assign unused_wdata = ^avs.avs_writedata;

    always_comb begin
        led_d    = led_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_led) begin
            led_d = avs.avs_writedata[LED_WIDTH-1:0];
        end
        if (wr_mask) begin
            mask_d = avs.avs_writedata[BTN_WIDTH-1:0];
        end
        if (wr_edge) begin
            edge_clr = avs.avs_writedata[BTN_WIDTH-1:0];
        end
        // A press arriving with a clear of the same bit keeps the bit set
        edge_d = (edge_q & ~edge_clr) | press;
        irq_d  = |(edge_q & mask_q);
    end

    // Read mux sees pre-write register values, so read-during-write
    // returns the old contents
    always_comb begin
        rdata_mux = '0;
        unique case (avs.avs_address)
            AddrData: rdata_mux[BTN_WIDTH-1:0] = db_q;
            AddrLed:  rdata_mux[LED_WIDTH-1:0] = led_q;
            AddrMask: rdata_mux[BTN_WIDTH-1:0] = mask_q;
            AddrEdge: rdata_mux[BTN_WIDTH-1:0] = edge_q;
            default:  rdata_mux = '0;
        endcase
        readdata_d = avs.avs_read ? rdata_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            led_q      <= led_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;
    assign led_out          = led_q;

endmodule

// File: tb/tb_avalon_button_led_pio.sv
// Directed bench for avalon_button_led_pio with a short debounce period;
// every comparison is an immediate assertion against hand-computed values.
module tb_avalon_button_led_pio;

    localparam int unsigned BTN_WIDTH = 4;
    localparam int unsigned LED_WIDTH = 10;
    localparam int unsigned DEB       = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 irq;
    logic [BTN_WIDTH-1:0] btn_n_in;
    logic [LED_WIDTH-1:0] led_out;

    int n_checks = 0;
    int n_fail   = 0;

    avalon_button_led_pio_if bus ();

    avalon_button_led_pio #(
        .BTN_WIDTH      (BTN_WIDTH),
        .LED_WIDTH      (LED_WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .irq     (irq),
        .btn_n_in(btn_n_in),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_write     = 1'b1;
        bus.avs_address   = a;
        bus.avs_writedata = d;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.avs_read    = 1'b1;
        bus.avs_address = a;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d               = bus.avs_readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] ext_led(input logic [LED_WIDTH-1:0] v);
        return {22'b0, v};
    endfunction

    function automatic logic [31:0] ext_bit(input logic v);
        return {31'b0, v};
    endfunction

    logic [31:0] d;

    initial begin
        reset_n           = 1'b0;
        btn_n_in          = '1;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        idle(3);
        check("rst_led", ext_led(led_out), 32'h0);
        check("rst_irq", ext_bit(irq), 32'h0);
        check("rst_rdata", bus.avs_readdata, 32'h0);
        reset_n = 1'b1;
        idle(2);

        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("rst_read_addr%0d", a), d, 32'h0);
        end

        // LED register
        wr(2'd1, 32'h0000_02A5);
        check("led_out_2a5", ext_led(led_out), 32'h2A5);
        rd(2'd1, d);
        check("led_read_2a5", d, 32'h2A5);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, d);
        check("led_read_trunc", d, 32'h3FF);

        // DATA is read-only
        wr(2'd0, 32'h0000_000F);
        rd(2'd0, d);
        check("data_ro", d, 32'h0);

        // Press button 2 with mask 0x4, track exact debounce latency
        wr(2'd2, 32'h4);
        rd(2'd2, d);
        check("mask_read", d, 32'h4);
        bus.avs_address = 2'd0;
        bus.avs_read    = 1'b1;
        btn_n_in[2]     = 1'b0;
        idle(DEB + 2);
        check("deb_before", bus.avs_readdata, 32'h0);
        idle(1);
        check("deb_after", bus.avs_readdata, 32'h4);
        bus.avs_read = 1'b0;
        idle(2);
        check("irq_press", ext_bit(irq), 32'h1);
        rd(2'd3, d);
        check("edge_press", d, 32'h4);

        btn_n_in[2] = 1'b1;
        idle(DEB + 9);
        check("irq_after_release", ext_bit(irq), 32'h1);
        rd(2'd3, d);
        check("edge_after_release", d, 32'h4);
        rd(2'd0, d);
        check("data_released", d, 32'h0);

        wr(2'd3, 32'h4);
        check("irq_clear_edge", ext_bit(irq), 32'h1);
        idle(1);
        check("irq_cleared", ext_bit(irq), 32'h0);
        rd(2'd3, d);
        check("edge_cleared", d, 32'h0);

        // Same press with interrupt masked
        wr(2'd2, 32'h0);
        btn_n_in[2] = 1'b0;
        idle(DEB + 9);
        rd(2'd3, d);
        check("edge_masked", d, 32'h4);
        check("irq_masked", ext_bit(irq), 32'h0);
        btn_n_in[2] = 1'b1;
        idle(DEB + 9);
        wr(2'd3, 32'h4);
        rd(2'd3, d);
        check("edge_masked_clr", d, 32'h0);

        // Glitch one cycle short of the debounce period
        btn_n_in[1] = 1'b0;
        idle(DEB - 1);
        btn_n_in[1] = 1'b1;
        idle(DEB + 9);
        rd(2'd0, d);
        check("glitch_data", d, 32'h0);
        rd(2'd3, d);
        check("glitch_edge", d, 32'h0);

        // Press of button 0 lands on the same edge as a W1C of bit 0
        btn_n_in[0] = 1'b0;
        idle(DEB + 2);
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        check("set_beats_clear", d, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        check("w1c_bit0", d, 32'h0);
        btn_n_in[0] = 1'b1;
        idle(DEB + 9);

        // Read and write to the same address in one cycle
        bus.avs_address   = 2'd1;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        bus.avs_writedata = 32'h155;
        @(negedge clk);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        check("rw_old_value", bus.avs_readdata, 32'h3FF);
        check("rw_led_out", ext_led(led_out), 32'h155);
        rd(2'd1, d);
        check("rw_new_value", d, 32'h155);

        // Reset mid-debounce and mid-read with buttons held
        wr(2'd1, 32'h3FF);
        wr(2'd2, 32'h8);
        btn_n_in[3] = 1'b0;
        idle(DEB + 9);
        check("irq_before_reset", ext_bit(irq), 32'h1);
        btn_n_in[0]     = 1'b0;
        idle(8);
        bus.avs_address = 2'd1;
        bus.avs_read    = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_led", ext_led(led_out), 32'h0);
        check("mid_rst_irq", ext_bit(irq), 32'h0);
        check("mid_rst_rdata", bus.avs_readdata, 32'h0);
        @(negedge clk);
        check("mid_rst_pending_read", bus.avs_readdata, 32'h0);
        reset_n         = 1'b1;
        bus.avs_address = 2'd0;
        idle(DEB + 2);
        check("post_rst_before", bus.avs_readdata, 32'h0);
        idle(1);
        check("post_rst_after", bus.avs_readdata, 32'h9);
        bus.avs_read = 1'b0;
        idle(3);
        rd(2'd3, d);
        check("post_rst_edge", d, 32'h9);
        check("post_rst_irq", ext_bit(irq), 32'h0);
        rd(2'd2, d);
        check("post_rst_mask", d, 32'h0);
        check("post_rst_led", ext_led(led_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_button_led_pio.md
Name: avalon_button_led_pio

Overview:
- Avalon-MM responder placed on the HPS lightweight bridge. It is the target end of the bus the HPS initiates.
- Reads the board push-buttons through a synchronizer and debouncer, and exposes them as a register.
- Captures button-press edges into a sticky register and raises a maskable level interrupt.
- Drives the LED bank from a software-writable register.

Parameters:
- BTN_WIDTH, 4, number of push-button inputs.
- LED_WIDTH, 10, number of LED outputs.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles needed to accept a button change (1 ms at 50 MHz). Legal range 2..2^20.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  word address of the register.
- avs_read  in  1  read strobe, one cycle.
- avs_write  in  1  write strobe, one cycle.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid the cycle after avs_read.
- irq  out  1  level interrupt to the HPS.
- btn_n_in  in  BTN_WIDTH  raw buttons, active-low, asynchronous to clk.
- led_out  out  LED_WIDTH  LED drive, active-high.

Behaviour:
- Reset (asynchronous, active-low): all registers clear.
  - avs_readdata=0, irq=0, led_out=0.
  - Synchronizer flops preset to 1 (button released).
  - Debounce counters=0, debounced state=0, mask=0, edge capture=0.
- Synchronizer: two flops per bit, then invert, giving btn_sync (1 = pressed).
- Debouncer (per bit):
  - If btn_sync equals the debounced bit, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit toggles and the counter clears on the same cycle.
  - Any glitch shorter than DEBOUNCE_CYCLES clears the counter; the debounced bit is unchanged.
  - Total latency from a clean pin change to the debounced change is 2 + DEBOUNCE_CYCLES cycles.
- Edge capture: when the debounced bit goes 0->1 (press), edge[i] sets the following cycle. Release does not set it.
- Register map (word addresses). Bits above the field width read as 0 and are ignored on write.
  - 0: DATA, read-only, debounced buttons [BTN_WIDTH-1:0]. Writes are ignored.
  - 1: LED, read/write [LED_WIDTH-1:0]. led_out equals this register directly, with no extra delay.
  - 2: IRQMASK, read/write [BTN_WIDTH-1:0].
  - 3: EDGE, read / write-1-to-clear [BTN_WIDTH-1:0].
- Bus timing:
  - No waitrequest.
  - Writes take effect on the clock edge where avs_write=1.
  - Read latency is fixed at 1. avs_readdata is registered, and holds its value when avs_read=0.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Simultaneous avs_read and avs_write to different addresses: both are serviced.
- Simultaneous W1C clear and a new press edge on the same bit: the set wins, so the bit stays 1.
- irq = OR(EDGE & IRQMASK), registered, one cycle after EDGE or IRQMASK changes.
  - irq stays high until software clears the bit or masks it.
- Reset asserted mid-debounce or mid-transaction:
  - Everything returns to reset values immediately.
  - A pending read returns 0.
  - A button still held at reset release needs a full debounce period before it is seen, and then produces an edge.

Test Plan:
- Reset, then read all 4 addresses -> each returns 0x00000000. irq=0, led_out=0.
- Write 0x2A5 to addr 1, then read addr 1 -> led_out=10'h2A5 on the cycle after the write, and readdata=0x000002A5 one cycle after avs_read. Then write 0xFFFFFFFF -> readback 0x3FF.
- With DEBOUNCE_CYCLES=16, hold btn_n_in[2]=0 -> addr 0 reads 0x4 starting 18 cycles after the pin change. Pulse btn_n_in[1] low for 15 cycles -> addr 0 bit1 stays 0 and EDGE stays 0.
- IRQMASK=0x4, press button 2 -> EDGE=0x4 and irq=1. Release -> irq stays 1. Write 0x4 to addr 3 -> EDGE=0 and irq=0 the next cycle. Repeat with IRQMASK=0 -> EDGE=0x4 and irq stays 0.
- Arrange the debounced press of button 0 to land on the same cycle as a W1C write of 0x1 to addr 3 -> EDGE bit0 reads 1.
- Write to addr 0, then read it -> value unchanged. Assert reset_n low mid-debounce with led=0x3FF -> led_out=0 and irq=0 immediately. After release, the held button reaches DATA after 18 cycles and sets EDGE.
